// File: rtl/businv_decoder.sv
// Bus-invert receiver: restores data from W+1 line words, buffers it in a
// 2-entry FIFO and keeps transition / violation statistics for the link.
module businv_decoder #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int MAX_T = 4
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [W:0]       bus_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     dout,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] trans_total,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             viol_flag
);

   localparam int TW = $clog2(W + 2);

   function automatic logic [TW-1:0] popcnt(input logic [W:0] v);
      logic [TW-1:0] c;
      c = '0;
      for (int i = 0; i <= W; i++) c = c + TW'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   logic [W:0]    prev_bus;
   logic [1:0]    occ;
   logic [W-1:0]  tail;
   logic          push_p0, pop_p0, viol_p0;
   logic [TW-1:0] t_p0;
   logic [W-1:0]  data_p0;
   logic [CNT_W-1:0] one_c;

   assign one_c     = {{(CNT_W-1){1'b0}}, 1'b1};
   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign push_p0   = in_valid & in_ready;
   assign pop_p0    = out_valid & out_ready;
   assign t_p0      = popcnt(bus_in ^ prev_bus);
   assign viol_p0   = int'(t_p0) > MAX_T;
   assign data_p0   = bus_in[W-1:0] ^ {W{bus_in[W]}};

   // Accept edge: dout is the head register, tail holds the second entry
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         prev_bus <= '0;
         occ      <= 2'd0;
         dout     <= '0;
         tail     <= '0;
      end else begin
         if (push_p0) prev_bus <= bus_in;
         case ({push_p0, pop_p0})
            2'b10: begin
               if (occ == 2'd0) dout <= data_p0;
               else             tail <= data_p0;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2) dout <= tail;
               occ <= occ - 2'd1;
            end
            2'b11: dout <= data_p0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         trans_total <= '0;
         viol_cnt    <= '0;
         viol_flag   <= 1'b0;
      end else if (clr_stats) begin
         trans_total <= push_p0 ? CNT_W'(t_p0) : '0;
         viol_cnt    <= (push_p0 && viol_p0) ? one_c : '0;
         viol_flag   <= push_p0 && viol_p0;
      end else if (push_p0) begin
         trans_total <= sat_add(trans_total, CNT_W'(t_p0));
         if (viol_p0) begin
            viol_cnt  <= sat_add(viol_cnt, one_c);
            viol_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_businv_decoder.sv
// Self-checking bench for businv_decoder: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_businv_decoder;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  bus_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  dout;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        clr_stats = 1'b0;
   logic [15:0] trans_total;
   logic [15:0] viol_cnt;
   logic        viol_flag;

   int n_err = 0;
   int n_chk = 0;
   logic [8:0] pv = '0;

   businv_decoder dut (
      .ck(ck), .rst(rst), .bus_in(bus_in), .in_valid(in_valid),
      .in_ready(in_ready), .dout(dout), .out_valid(out_valid),
      .out_ready(out_ready), .clr_stats(clr_stats),
      .trans_total(trans_total), .viol_cnt(viol_cnt), .viol_flag(viol_flag)
   );

   always #5 ck = ~ck;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, statistics as plain saturating integers
   logic [7:0] m_q[$];
   logic [8:0] m_prev = '0;
   longint     m_total = 0, m_vc = 0;
   bit         m_vf = 0;
   localparam longint MAXC = 65535;

   always @(posedge ck or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_prev  <= '0;
         m_total <= 0;
         m_vc    <= 0;
         m_vf    <= 0;
      end else begin
         automatic bit     acc = in_valid && (m_q.size() < 2);
         automatic bit     pop = out_ready && (m_q.size() > 0);
         automatic longint t   = $countones(bus_in ^ m_prev);
         automatic bit     bad = acc && (t > 4);
         if (pop) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(bus_in[8] ? ~bus_in[7:0] : bus_in[7:0]);
            m_prev <= bus_in;
         end
         if (clr_stats) begin
            m_total <= acc ? t : 0;
            m_vc    <= bad ? 1 : 0;
            m_vf    <= bad;
         end else if (acc) begin
            m_total <= (m_total + t > MAXC) ? MAXC : m_total + t;
            if (bad) begin
               m_vc <= (m_vc + 1 > MAXC) ? MAXC : m_vc + 1;
               m_vf <= 1;
            end
         end
      end
   end

   always @(negedge ck) begin
      if (!rst) begin
         chk("m_out_valid", out_valid, m_q.size() != 0);
         chk("m_in_ready", in_ready, m_q.size() < 2);
         if (m_q.size() != 0) chk("m_dout", dout, m_q[0]);
         chk("m_trans_total", trans_total, m_total);
         chk("m_viol_cnt", viol_cnt, m_vc);
         chk("m_viol_flag", viol_flag, m_vf);
      end
   end

   task automatic send(input logic [8:0] w);
      int n = 0;
      logic acc;
      bus_in   = w;
      in_valid = 1'b1;
      do begin
         acc = in_ready;
         @(posedge ck); #1;
         n++;
      end while (!acc && n < 50);
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
      pv = w;
   endtask

   function automatic logic [7:0] dec(input logic [8:0] w);
      return w[8] ? ~w[7:0] : w[7:0];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge ck);
      #1 rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dout", dout, 0);
      chk("rst_trans_total", trans_total, 0);
      chk("rst_viol_flag", viol_flag, 0);

      // Basic decode and statistics
      out_ready = 1'b1;
      send(9'h100);
      chk("t1_dout", dout, 8'hFF);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_trans_total", trans_total, 1);
      chk("t1_viol_flag", viol_flag, 0);
      send(9'h10F);
      chk("t2a_dout", dout, 8'hF0);
      chk("t2a_trans_total", trans_total, 5);
      chk("t2a_viol_cnt", viol_cnt, 0);
      send(9'h0F0);
      chk("t2b_dout", dout, 8'hF0);
      chk("t2b_trans_total", trans_total, 14);
      chk("t2b_viol_cnt", viol_cnt, 1);
      chk("t2b_viol_flag", viol_flag, 1);
      send(9'h0F0);
      chk("t2c_trans_total", trans_total, 14);
      chk("t2c_viol_cnt", viol_cnt, 1);
      @(posedge ck); #1;

      // Backpressure: third word waits while full
      out_ready = 1'b0;
      send(9'h0AA);
      send(9'h033);
      chk("t3_full", in_ready, 0);
      bus_in = 9'h1C3; in_valid = 1'b1;
      repeat (3) @(posedge ck);
      #1;
      chk("t3_still_full", in_ready, 0);
      chk("t3_head", dout, 8'hAA);
      out_ready = 1'b1;
      send(9'h1C3);
      chk("t3_third", dout, 8'h3C);
      @(posedge ck); #1;
      chk("t3_drained", out_valid, 0);

      // Occupancy 1 with push and pop every cycle
      for (int i = 0; i < 20; i++) begin
         automatic logic [8:0] w = 9'(i * 29 + 7);
         send(w);
         chk("t4_out_valid", out_valid, 1);
         chk("t4_in_ready", in_ready, 1);
         chk("t4_dout", dout, dec(w));
      end
      @(posedge ck); #1;
      chk("t4_empty", out_valid, 0);
      chk("t4_dout_hold", dout, dec(9'(19 * 29 + 7)));

      // Saturation and clear with simultaneous accept
      clr_stats = 1'b1;
      @(posedge ck); #1;
      clr_stats = 1'b0;
      chk("t5_clr_total", trans_total, 0);
      chk("t5_clr_flag", viol_flag, 0);
      for (int i = 0; i < 7281; i++) send(~pv);
      send(pv ^ 9'h01F);
      chk("t5_total_pre", trans_total, 16'hFFFE);
      send(pv ^ 9'h00F);
      chk("t5_total_sat", trans_total, 16'hFFFF);
      clr_stats = 1'b1;
      send(pv ^ 9'h003);
      clr_stats = 1'b0;
      chk("t5_clr_acc_total", trans_total, 2);
      chk("t5_clr_acc_flag", viol_flag, 0);
      chk("t5_clr_acc_cnt", viol_cnt, 0);
      @(posedge ck); #1;

      // Reset mid-stream with two words queued
      out_ready = 1'b0;
      send(9'h055);
      send(9'h0AA);
      chk("t6_full", in_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_total", trans_total, 0);
      chk("t6_viol_cnt", viol_cnt, 0);
      chk("t6_viol_flag", viol_flag, 0);
      chk("t6_dout", dout, 0);
      @(posedge ck); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(9'h003);
      chk("t6_after_total", trans_total, 2);
      chk("t6_after_dout", dout, 8'h03);
      repeat (3) @(posedge ck);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
